// File: rtl/sb_i2c_initiator.sv
// Host-side initiator for the iCE40UP hard I2C system bus (SB) port.
// Runs single register reads/writes and poll-until-match status reads.
module sb_i2c_initiator #(
    parameter logic [3:0]  BUS_ADDR74  = 4'b0001,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned POLL_LIMIT  = 1000,
    parameter int unsigned POLL_GAP    = 16
) (
    input  logic       SBCLKI,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic       cmd_poll,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic [7:0] cmd_mask,
    input  logic [7:0] cmd_match,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       SBRWI,
    output logic       SBSTBI,
    output logic [7:0] SBADRI,
    output logic [7:0] SBDATI,
    input  logic [7:0] SBDATO,
    input  logic       SBACKO
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP,
        DONE
    } state_t;

    localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_TO   = 2'b01;
    localparam logic [1:0] ERR_POLL = 2'b10;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic        poll_q, poll_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  match_q, match_d;
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        ready_q, ready_d;
    logic        rvalid_q, rvalid_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic        rwi_q, rwi_d;
    logic        stb_q, stb_d;
    logic [7:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;

    logic        hit;
    logic [15:0] cyc_inc;
    logic [15:0] pcnt_inc;

    assign hit      = ((SBDATO ^ match_q) & mask_q) == 8'h00;
    assign cyc_inc  = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
    assign pcnt_inc = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;

    always_ff @(posedge SBCLKI or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            poll_q   <= 1'b0;
            mask_q   <= 8'h00;
            match_q  <= 8'h00;
            cyc_q    <= 16'd0;
            pcnt_q   <= 16'd0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 8'h00;
            err_q    <= ERR_OK;
            rwi_q    <= 1'b0;
            stb_q    <= 1'b0;
            adr_q    <= 8'h00;
            dat_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            poll_q   <= poll_d;
            mask_q   <= mask_d;
            match_q  <= match_d;
            cyc_q    <= cyc_d;
            pcnt_q   <= pcnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rwi_q    <= rwi_d;
            stb_q    <= stb_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        poll_d   = poll_q;
        mask_d   = mask_q;
        match_d  = match_q;
        cyc_d    = cyc_q;
        pcnt_d   = pcnt_q;
        ready_d  = ready_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rwi_d    = rwi_q;
        stb_d    = stb_q;
        adr_d    = adr_q;
        dat_d    = dat_q;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid && ready_q) begin
                    we_d    = cmd_we;
                    poll_d  = cmd_poll & ~cmd_we;
                    mask_d  = cmd_mask;
                    match_d = cmd_match;
                    rwi_d   = cmd_we;
                    adr_d   = {BUS_ADDR74, cmd_addr};
                    dat_d   = cmd_we ? cmd_wdata : 8'h00;
                    cyc_d   = 16'd0;
                    pcnt_d  = 16'd0;
                    stb_d   = 1'b1;
                    ready_d = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                cyc_d = cyc_inc;
                // An ack always beats a timeout landing in the same cycle.
                if (SBACKO) begin
                    if (!poll_q || hit) begin
                        rdata_d  = we_q ? 8'h00 : SBDATO;
                        err_d    = ERR_OK;
                        stb_d    = 1'b0;
                        rvalid_d = 1'b1;
                        state_d  = DONE;
                    end else if (pcnt_q >= POLL_LAST) begin
                        rdata_d  = SBDATO;
                        err_d    = ERR_POLL;
                        stb_d    = 1'b0;
                        rvalid_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        pcnt_d  = pcnt_inc;
                        cyc_d   = 16'd0;
                        stb_d   = 1'b0;
                        state_d = GAP;
                    end
                end else if (cyc_q >= ACK_LAST) begin
                    rdata_d  = 8'h00;
                    err_d    = ERR_TO;
                    stb_d    = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = DONE;
                end
            end
            GAP: begin
                cyc_d = cyc_inc;
                if (cyc_q >= GAP_LAST) begin
                    cyc_d   = 16'd0;
                    stb_d   = 1'b1;
                    state_d = XFER;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rvalid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign SBRWI     = rwi_q;
    assign SBSTBI    = stb_q;
    assign SBADRI    = adr_q;
    assign SBDATI    = dat_q;

endmodule

// File: tb/tb_sb_i2c_initiator.sv
// Randomized bench for sb_i2c_initiator with a scripted SB responder
// and a transaction-level reference model.
module tb_sb_i2c_initiator;

    localparam int ACK_TO = 8;
    localparam int PLIM   = 5;
    localparam int PGAP   = 4;
    localparam logic [3:0] BA = 4'b0001;

    logic       SBCLKI = 1'b0;
    logic       RST = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic       cmd_poll = 1'b0;
    logic [3:0] cmd_addr = 4'h0;
    logic [7:0] cmd_wdata = 8'h00;
    logic [7:0] cmd_mask = 8'h00;
    logic [7:0] cmd_match = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       SBRWI;
    logic       SBSTBI;
    logic [7:0] SBADRI;
    logic [7:0] SBDATI;
    logic [7:0] SBDATO = 8'h00;
    logic       SBACKO = 1'b0;

    always #5 SBCLKI = ~SBCLKI;

    sb_i2c_initiator #(
        .BUS_ADDR74 (BA),
        .ACK_TIMEOUT(ACK_TO),
        .POLL_LIMIT (PLIM),
        .POLL_GAP   (PGAP)
    ) dut (
        .SBCLKI   (SBCLKI),
        .RST      (RST),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_poll (cmd_poll),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_mask (cmd_mask),
        .cmd_match(cmd_match),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .SBRWI    (SBRWI),
        .SBSTBI   (SBSTBI),
        .SBADRI   (SBADRI),
        .SBDATI   (SBDATI),
        .SBDATO   (SBDATO),
        .SBACKO   (SBACKO)
    );

    int nchecks = 0;
    int nerrors = 0;

    // Responder script: ack on strobe cycle w (0 = never), returning d.
    int         scr_wait[$];
    logic [7:0] scr_data[$];
    int         m_ws[$];
    logic [7:0] m_ds[$];

    int         stb_len_q[$];
    int         gap_len_q[$];
    int         hi_cnt = 0;
    int         lo_cnt = 0;
    int         stab_err = 0;
    int         first_gap = -1;
    int         rsp_cnt = 0;
    bit         stb_seen = 0;
    bit         acked = 0;
    bit         force_ack = 0;
    logic [7:0] adr0, dat0;
    logic       rw0;

    int         obs_lat;
    bit         obs_got;
    logic [7:0] obs_rdata;
    logic [1:0] obs_err;
    logic       obs_rdy_rsp, obs_stb_rsp, obs_valid_after, obs_rdy_after;

    logic [1:0] exp_err;
    logic [7:0] exp_rdata;
    int         exp_lat;
    int         exp_len[$];

    always begin
        @(posedge SBCLKI);
        #1;
        if (rsp_valid === 1'b1) rsp_cnt++;
        SBACKO = force_ack;
        SBDATO = 8'($urandom);
        if (SBSTBI === 1'b1) begin
            if (hi_cnt == 0) begin
                if (stb_seen) gap_len_q.push_back(lo_cnt);
                else first_gap = lo_cnt;
                stb_seen = 1;
                adr0 = SBADRI;
                dat0 = SBDATI;
                rw0 = SBRWI;
                acked = 0;
            end else if (SBADRI !== adr0 || SBDATI !== dat0 || SBRWI !== rw0) begin
                stab_err++;
            end
            hi_cnt++;
            lo_cnt = 0;
            if (!acked && scr_wait.size() > 0 && scr_wait[0] == hi_cnt) begin
                SBACKO = 1'b1;
                SBDATO = scr_data[0];
                acked = 1;
            end
        end else begin
            if (hi_cnt > 0) begin
                stb_len_q.push_back(hi_cnt);
                if (scr_wait.size() > 0) begin
                    void'(scr_wait.pop_front());
                    void'(scr_data.pop_front());
                end
            end
            hi_cnt = 0;
            lo_cnt++;
        end
    end

    task automatic clear_scripts();
        scr_wait.delete();
        scr_data.delete();
        m_ws.delete();
        m_ds.delete();
    endtask

    task automatic load(input int w, input logic [7:0] d);
        scr_wait.push_back(w);
        scr_data.push_back(d);
        m_ws.push_back(w);
        m_ds.push_back(d);
    endtask

    // Expected outcome from the command rules, one strobe at a time.
    task automatic model(input bit we, input bit poll, input logic [7:0] mk,
                         input logic [7:0] mt);
        int w, total;
        exp_len.delete();
        exp_err = 2'b00;
        exp_rdata = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            w = (i < m_ws.size()) ? m_ws[i] : 0;
            if (w < 1 || w > ACK_TO) begin
                exp_len.push_back(ACK_TO);
                exp_err = 2'b01;
                exp_rdata = 8'h00;
                break;
            end
            exp_len.push_back(w);
            if (we) begin
                exp_rdata = 8'h00;
                break;
            end
            exp_rdata = m_ds[i];
            if (!poll || (m_ds[i] & mk) == (mt & mk)) break;
            if (i + 1 == PLIM) begin
                exp_err = 2'b10;
                break;
            end
        end
        total = 0;
        foreach (exp_len[i]) total += exp_len[i];
        exp_lat = 1 + total + PGAP * (exp_len.size() - 1) + 1;
    endtask

    function automatic bit lens_ok();
        if (stb_len_q.size() != exp_len.size()) return 0;
        foreach (exp_len[i]) if (stb_len_q[i] != exp_len[i]) return 0;
        return 1;
    endfunction

    function automatic bit gaps_ok();
        if (gap_len_q.size() != exp_len.size() - 1) return 0;
        foreach (gap_len_q[i]) if (gap_len_q[i] != PGAP) return 0;
        return 1;
    endfunction

    task automatic do_cmd(input bit we, input bit poll, input logic [3:0] addr,
                          input logic [7:0] wd, input logic [7:0] mk,
                          input logic [7:0] mt);
        int n;
        stb_len_q.delete();
        gap_len_q.delete();
        stab_err = 0;
        stb_seen = 0;
        first_gap = -1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge SBCLKI);
            #1;
            n++;
        end
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_poll = poll;
        cmd_addr = addr;
        cmd_wdata = wd;
        cmd_mask = mk;
        cmd_match = mt;
        obs_lat = 1;
        obs_got = 0;
        @(posedge SBCLKI);
        #1;
        cmd_valid = 1'b0;
        cmd_we = 1'($urandom);
        cmd_addr = 4'($urandom);
        cmd_wdata = 8'($urandom);
        obs_lat = 2;
        while (!obs_got && obs_lat < 3000) begin
            if (rsp_valid === 1'b1) obs_got = 1;
            else begin
                @(posedge SBCLKI);
                #1;
                obs_lat++;
            end
        end
        nchecks++;
        if (!obs_got) begin
            nerrors++;
            $display("FAIL rsp_wait: no rsp_valid after %0d cycles", obs_lat);
        end
        obs_rdata = rsp_rdata;
        obs_err = rsp_err;
        obs_rdy_rsp = cmd_ready;
        obs_stb_rsp = SBSTBI;
        @(posedge SBCLKI);
        #1;
        obs_valid_after = rsp_valid;
        obs_rdy_after = cmd_ready;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge SBCLKI);
        #1;
        nchecks++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, SBRWI, SBSTBI, SBADRI, SBDATI} !== 30'd0) begin
            nerrors++;
            $display("FAIL reset_outs: got %h want 0",
                     {cmd_ready, rsp_valid, rsp_rdata, rsp_err, SBRWI, SBSTBI, SBADRI, SBDATI});
        end
        RST = 1'b0;
        @(posedge SBCLKI);
        #1;
        nchecks++;
        if (cmd_ready !== 1'b1) begin
            nerrors++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        clear_scripts();
        load(2, 8'h3C);
        model(1, 0, 8'h00, 8'h00);
        do_cmd(1, 0, 4'h8, 8'h5A, 8'h00, 8'h00);
        nchecks++;
        if ({rw0, adr0, dat0} !== {1'b1, 8'h18, 8'h5A}) begin
            nerrors++;
            $display("FAIL wr_bus: got rw=%b adr=%h dat=%h want rw=1 adr=18 dat=5a", rw0, adr0, dat0);
        end
        nchecks++;
        if (!lens_ok() || stb_len_q[0] != 2) begin
            nerrors++;
            $display("FAIL wr_strobe: got %0d strobes want one of 2 cycles", stb_len_q.size());
        end
        nchecks++;
        if (obs_err !== 2'b00 || obs_rdata !== 8'h00 || obs_lat != exp_lat) begin
            nerrors++;
            $display("FAIL wr_rsp: got err=%b rdata=%h lat=%0d want err=00 rdata=00 lat=%0d",
                     obs_err, obs_rdata, obs_lat, exp_lat);
        end
        nchecks++;
        if (obs_valid_after !== 1'b0 || obs_stb_rsp !== 1'b0) begin
            nerrors++;
            $display("FAIL wr_pulse: got valid_after=%b stb=%b want 0 0", obs_valid_after, obs_stb_rsp);
        end
    endtask

    task automatic test_read();
        clear_scripts();
        load(1, 8'hA5);
        model(0, 0, 8'h00, 8'h00);
        do_cmd(0, 0, 4'hC, 8'hFF, 8'h00, 8'h00);
        nchecks++;
        if (obs_rdata !== 8'hA5 || obs_err !== 2'b00 || obs_lat != 3) begin
            nerrors++;
            $display("FAIL rd_rsp: got rdata=%h err=%b lat=%0d want a5 00 3", obs_rdata, obs_err, obs_lat);
        end
        nchecks++;
        if ({rw0, adr0, dat0} !== {1'b0, 8'h1C, 8'h00}) begin
            nerrors++;
            $display("FAIL rd_bus: got rw=%b adr=%h dat=%h want 0 1c 00", rw0, adr0, dat0);
        end
        nchecks++;
        if (obs_rdy_rsp !== 1'b0 || obs_rdy_after !== 1'b1) begin
            nerrors++;
            $display("FAIL rd_ready: got %b%b want 01", obs_rdy_rsp, obs_rdy_after);
        end
    endtask

    task automatic test_poll();
        clear_scripts();
        for (int i = 0; i < 3; i++) load(1 + int'($urandom_range(0, 2)), 8'h00);
        load(2, 8'h04);
        model(0, 1, 8'h04, 8'h04);
        do_cmd(0, 1, 4'h1, 8'h00, 8'h04, 8'h04);
        nchecks++;
        if (stb_len_q.size() != 4 || !lens_ok() || !gaps_ok()) begin
            nerrors++;
            $display("FAIL poll_strobes: got %0d strobes %0d gaps want 4 strobes gaps of %0d",
                     stb_len_q.size(), gap_len_q.size(), PGAP);
        end
        nchecks++;
        if (obs_rdata !== 8'h04 || obs_err !== 2'b00 || obs_lat != exp_lat) begin
            nerrors++;
            $display("FAIL poll_rsp: got rdata=%h err=%b lat=%0d want 04 00 %0d",
                     obs_rdata, obs_err, obs_lat, exp_lat);
        end
    endtask

    task automatic test_poll_exhaust();
        clear_scripts();
        for (int i = 0; i < PLIM; i++) load(1, 8'($urandom) & 8'hFB);
        model(0, 1, 8'h04, 8'h04);
        do_cmd(0, 1, 4'h2, 8'h00, 8'h04, 8'h04);
        nchecks++;
        if (stb_len_q.size() != PLIM || !gaps_ok()) begin
            nerrors++;
            $display("FAIL exh_strobes: got %0d want %0d", stb_len_q.size(), PLIM);
        end
        nchecks++;
        if (obs_err !== 2'b10 || obs_rdata !== exp_rdata) begin
            nerrors++;
            $display("FAIL exh_rsp: got err=%b rdata=%h want 10 %h", obs_err, obs_rdata, exp_rdata);
        end
    endtask

    task automatic test_timeout();
        int base;
        clear_scripts();
        model(0, 0, 8'h00, 8'h00);
        do_cmd(0, 0, 4'h5, 8'h00, 8'h00, 8'h00);
        nchecks++;
        if (stb_len_q.size() != 1 || stb_len_q[0] != ACK_TO) begin
            nerrors++;
            $display("FAIL to_strobe: got %0d strobes want one of %0d cycles", stb_len_q.size(), ACK_TO);
        end
        nchecks++;
        if (obs_err !== 2'b01 || obs_rdata !== 8'h00 || obs_lat != exp_lat) begin
            nerrors++;
            $display("FAIL to_rsp: got err=%b rdata=%h lat=%0d want 01 00 %0d",
                     obs_err, obs_rdata, obs_lat, exp_lat);
        end
        base = rsp_cnt;
        force_ack = 1;
        repeat (3) @(posedge SBCLKI);
        #1;
        force_ack = 0;
        repeat (4) @(posedge SBCLKI);
        #1;
        nchecks++;
        if (rsp_cnt != base || SBSTBI !== 1'b0 || cmd_ready !== 1'b1) begin
            nerrors++;
            $display("FAIL idle_ack: got rsp=%0d stb=%b rdy=%b want 0 0 1", rsp_cnt - base, SBSTBI, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        clear_scripts();
        cmd_valid = 1'b1;
        cmd_we = 1'b1;
        cmd_poll = 1'b0;
        cmd_addr = 4'h2;
        cmd_wdata = 8'h11;
        @(posedge SBCLKI);
        #1;
        cmd_valid = 1'b0;
        @(posedge SBCLKI);
        #1;
        nchecks++;
        if (SBSTBI !== 1'b1) begin
            nerrors++;
            $display("FAIL mid_stb: got %b want 1", SBSTBI);
        end
        base = rsp_cnt;
        #2 RST = 1'b1;
        #1;
        nchecks++;
        if (SBSTBI !== 1'b0 || cmd_ready !== 1'b0) begin
            nerrors++;
            $display("FAIL mid_rst: got stb=%b rdy=%b want 0 0", SBSTBI, cmd_ready);
        end
        repeat (3) @(posedge SBCLKI);
        #1;
        RST = 1'b0;
        repeat (20) @(posedge SBCLKI);
        #1;
        nchecks++;
        if (rsp_cnt != base || SBSTBI !== 1'b0) begin
            nerrors++;
            $display("FAIL mid_norsp: got rsp=%0d stb=%b want 0 0", rsp_cnt - base, SBSTBI);
        end
        clear_scripts();
        load(1, 8'h00);
        model(1, 0, 8'h00, 8'h00);
        do_cmd(1, 0, 4'h3, 8'h77, 8'h00, 8'h00);
        nchecks++;
        if (obs_err !== 2'b00 || adr0 !== 8'h13 || dat0 !== 8'h77 || obs_lat != exp_lat) begin
            nerrors++;
            $display("FAIL mid_after: got err=%b adr=%h dat=%h lat=%0d want 00 13 77 %0d",
                     obs_err, adr0, dat0, obs_lat, exp_lat);
        end
    endtask

    task automatic test_back_to_back();
        clear_scripts();
        load(1, 8'h00);
        do_cmd(1, 0, 4'h4, 8'h01, 8'h00, 8'h00);
        load(2, 8'h9E);
        do_cmd(0, 0, 4'h4, 8'h00, 8'h00, 8'h00);
        nchecks++;
        if (first_gap != 2 || obs_rdata !== 8'h9E || obs_err !== 2'b00) begin
            nerrors++;
            $display("FAIL b2b: got gap=%0d rdata=%h err=%b want 2 9e 00", first_gap, obs_rdata, obs_err);
        end
    endtask

    task automatic test_random();
        bit we, poll;
        logic [3:0] addr;
        logic [7:0] wd, mk, mt, d;
        int w;
        for (int it = 0; it < 30; it++) begin
            we = 1'($urandom);
            poll = 1'($urandom);
            addr = 4'($urandom);
            wd = 8'($urandom);
            mk = 8'($urandom);
            mt = 8'($urandom);
            clear_scripts();
            for (int k = 0; k < PLIM; k++) begin
                w = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 3));
                d = 8'($urandom);
                if ($urandom_range(0, 2) == 0) d = (mt & mk) | (d & ~mk);
                load(w, d);
            end
            model(we, poll, mk, mt);
            do_cmd(we, poll, addr, wd, mk, mt);
            nchecks++;
            if (obs_err !== exp_err || obs_rdata !== exp_rdata || obs_lat != exp_lat) begin
                nerrors++;
                $display("FAIL rnd%0d_rsp: got err=%b rdata=%h lat=%0d want %b %h %0d",
                         it, obs_err, obs_rdata, obs_lat, exp_err, exp_rdata, exp_lat);
            end
            nchecks++;
            if (!lens_ok() || !gaps_ok() || stab_err != 0) begin
                nerrors++;
                $display("FAIL rnd%0d_bus: got %0d strobes stab=%0d want %0d strobes stab=0",
                         it, stb_len_q.size(), stab_err, exp_len.size());
            end
            nchecks++;
            if ({rw0, adr0, dat0} !== {we, BA, addr, (we ? wd : 8'h00)}) begin
                nerrors++;
                $display("FAIL rnd%0d_addr: got %b %h %h want %b %h %h",
                         it, rw0, adr0, dat0, we, {BA, addr}, we ? wd : 8'h00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_poll();
        test_poll_exhaust();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
